// File: rtl/usb_rx_phy.sv
// -----------------------------------------------------------------------------
// usb_rx_phy
//
// Full-speed USB receive front end. The raw D+/D- pins are synchronised and
// sampled at 48 MHz (4 clocks per 12 Mb/s bit). A phase counter re-centres on
// every line transition and strobes one sample per bit. Each strobe is
// NRZI-decoded; the FSM detects SYNC, removes stuffed bits, assembles
// LSB-first bytes and reports end of packet and errors.
//
// Parameters:
//   SAMPLE_PHASE      phase-counter value (0..3) at which a bit is sampled
//   SYNC_MIN_ZEROS    minimum decoded zeros before the SYNC-terminating one
//   RESET_SE0_CYCLES  SE0 clocks that signal a bus reset (1..127)
//
// Ports:
//   clock48    in   48 MHz clock
//   reset      in   synchronous, active-high reset
//   data       in   D+ pin (asynchronous)
//   data_n     in   D- pin (asynchronous)
//   rx_data    out  last assembled byte, valid with rx_valid
//   rx_valid   out  one-cycle pulse per received byte
//   rx_sop     out  one-cycle pulse when SYNC completes
//   rx_eop     out  one-cycle pulse when EOP (SE0) is sampled
//   rx_error   out  one-cycle pulse on stuff error, SE1 or partial byte at EOP
//   rx_active  out  high while receiving packet data
//   usb_reset  out  bus-reset level indication
//
// Optional feature (macro USB_RX_BUS_RESET_EN):
//   defined   - a saturating SE0 cycle counter raises usb_reset after
//               RESET_SE0_CYCLES consecutive SE0 clocks; usb_reset clears the
//               cycle after the first J/K sample, and the FSM is held in
//               WAIT_IDLE while it is high.
//   undefined - no counter, usb_reset is tied to 0.
// -----------------------------------------------------------------------------
module usb_rx_phy #(
    parameter int unsigned SAMPLE_PHASE     = 2,
    parameter int unsigned SYNC_MIN_ZEROS   = 5,
    parameter int unsigned RESET_SE0_CYCLES = 120
) (
    input  logic       clock48,
    input  logic       reset,
    input  logic       data,
    input  logic       data_n,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sop,
    output logic       rx_eop,
    output logic       rx_error,
    output logic       rx_active,
    output logic       usb_reset
);

    // Line states as {D+, D-}
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    localparam logic [1:0] STROBE_PHASE = 2'(SAMPLE_PHASE);
    localparam logic [2:0] ZEROS_MIN    = 3'(SYNC_MIN_ZEROS);

    // Elaboration-time range checks on the parameters.
    if (SAMPLE_PHASE > 3) begin : g_bad_sample_phase
        $error("usb_rx_phy: SAMPLE_PHASE must be 0..3");
    end
    if (SYNC_MIN_ZEROS > 7) begin : g_bad_sync_zeros
        $error("usb_rx_phy: SYNC_MIN_ZEROS must be 0..7");
    end
    if (RESET_SE0_CYCLES < 1 || RESET_SE0_CYCLES > 127) begin : g_bad_reset_cycles
        $error("usb_rx_phy: RESET_SE0_CYCLES must be 1..127");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SYNC      = 2'd1,
        ST_DATA      = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } state_t;

    // Synchroniser and previous-sample flops
    logic       dp_s1_q, dp_s1_d, dp_s2_q, dp_s2_d;
    logic       dn_s1_q, dn_s1_d, dn_s2_q, dn_s2_d;
    logic [1:0] line_prev_q, line_prev_d;
    logic [1:0] phase_q, phase_d;

    // FSM and datapath flops
    state_t     state_q, state_d;
    logic       prev_j_q, prev_j_d;
    logic [2:0] zeros_q, zeros_d;
    logic [2:0] ones_q, ones_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d;

    // Output registers
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_sop_q, rx_sop_d;
    logic       rx_eop_q, rx_eop_d;
    logic       rx_error_q, rx_error_d;

    logic [1:0] line_cur;
    logic       cur_jk, cur_j, prev_jk, prev_se0;
    logic       edge_seen, strobe, nrzi_bit;
    logic       bus_reset_active;

    assign line_cur = {dp_s2_q, dn_s2_q};
    assign cur_j    = (line_cur == LINE_J);
    assign cur_jk   = (line_cur == LINE_J) || (line_cur == LINE_K);
    assign prev_jk  = (line_prev_q == LINE_J) || (line_prev_q == LINE_K);
    assign prev_se0 = (line_prev_q == LINE_SE0);

    // Re-centre only on J<->K or SE0->J/K; J/K->SE0 and anything from SE1
    // leave the phase free-running so EOP is still sampled on bit boundaries.
    assign edge_seen = cur_jk && (line_cur != line_prev_q) && (prev_jk || prev_se0);
    assign strobe    = (phase_q == STROBE_PHASE);
    // NRZI: no change from the previous strobe decodes as 1
    assign nrzi_bit  = (cur_j == prev_j_q);

    always_comb begin
        dp_s1_d     = data;
        dn_s1_d     = data_n;
        dp_s2_d     = dp_s1_q;
        dn_s2_d     = dn_s1_q;
        line_prev_d = line_cur;
        phase_d     = edge_seen ? 2'd0 : phase_q + 2'd1;
    end

`ifdef USB_RX_BUS_RESET_EN
    localparam logic [6:0] SE0_RESET_CNT = 7'(RESET_SE0_CYCLES);

    logic [6:0] se0_cnt_q, se0_cnt_d;
    logic       usb_reset_q, usb_reset_d;

    always_comb begin
        se0_cnt_d = 7'd0;
        if (line_cur == LINE_SE0) begin
            se0_cnt_d = (se0_cnt_q == 7'h7f) ? se0_cnt_q : se0_cnt_q + 7'd1;
        end
        // Hold once raised until a J or K is seen on the synchronised line
        if (cur_jk) begin
            usb_reset_d = 1'b0;
        end else begin
            usb_reset_d = usb_reset_q || (se0_cnt_d == SE0_RESET_CNT);
        end
    end

    always_ff @(posedge clock48) begin
        if (reset) begin
            se0_cnt_q   <= 7'd0;
            usb_reset_q <= 1'b0;
        end else begin
            se0_cnt_q   <= se0_cnt_d;
            usb_reset_q <= usb_reset_d;
        end
    end

    assign bus_reset_active = usb_reset_q;
    assign usb_reset        = usb_reset_q;
`else
    assign bus_reset_active = 1'b0;
    assign usb_reset        = 1'b0;
`endif

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        prev_j_d   = prev_j_q;
        zeros_d    = zeros_q;
        ones_d     = ones_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_sop_d   = 1'b0;
        rx_eop_d   = 1'b0;
        rx_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                prev_j_d = 1'b1;
                zeros_d  = 3'd0;
                ones_d   = 3'd0;
                bitcnt_d = 3'd0;
                // The first K after idle J is already the first SYNC zero
                if (strobe && line_cur == LINE_K) begin
                    prev_j_d = 1'b0;
                    zeros_d  = 3'd1;
                    state_d  = ST_SYNC;
                end
            end

            ST_SYNC: begin
                if (strobe) begin
                    if (cur_jk) begin
                        prev_j_d = cur_j;
                        if (!nrzi_bit) begin
                            zeros_d = (zeros_q == 3'd7) ? zeros_q : zeros_q + 3'd1;
                        end else if (zeros_q >= ZEROS_MIN) begin
                            rx_sop_d = 1'b1;
                            ones_d   = 3'd1;  // the SYNC-ending one starts the run
                            bitcnt_d = 3'd0;
                            state_d  = ST_DATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // Noise rather than a packet: drop silently
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (strobe) begin
                    if (line_cur == LINE_SE0) begin
                        rx_eop_d   = 1'b1;
                        rx_error_d = (bitcnt_q != 3'd0);
                        state_d    = ST_WAIT_IDLE;
                    end else if (line_cur == LINE_SE1) begin
                        rx_error_d = 1'b1;
                        state_d    = ST_WAIT_IDLE;
                    end else begin
                        prev_j_d = cur_j;
                        if (ones_q == 3'd6) begin
                            // Stuff position: a zero is dropped, a one is illegal
                            if (nrzi_bit) begin
                                rx_error_d = 1'b1;
                                state_d    = ST_WAIT_IDLE;
                            end else begin
                                ones_d = 3'd0;
                            end
                        end else begin
                            ones_d  = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                            shift_d = {nrzi_bit, shift_q[7:1]};
                            if (bitcnt_q == 3'd7) begin
                                rx_data_d  = {nrzi_bit, shift_q[7:1]};
                                rx_valid_d = 1'b1;
                                bitcnt_d   = 3'd0;
                            end else begin
                                bitcnt_d = bitcnt_q + 3'd1;
                            end
                        end
                    end
                end
            end

            ST_WAIT_IDLE: begin
                if (strobe && line_cur == LINE_J) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (bus_reset_active) begin
            state_d = ST_WAIT_IDLE;
        end
    end

    always_ff @(posedge clock48) begin
        if (reset) begin
            dp_s1_q     <= 1'b1;
            dn_s1_q     <= 1'b0;
            dp_s2_q     <= 1'b1;
            dn_s2_q     <= 1'b0;
            line_prev_q <= LINE_J;
            phase_q     <= 2'd0;
            state_q     <= ST_IDLE;
            prev_j_q    <= 1'b1;
            zeros_q     <= 3'd0;
            ones_q      <= 3'd0;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_sop_q    <= 1'b0;
            rx_eop_q    <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            dp_s1_q     <= dp_s1_d;
            dn_s1_q     <= dn_s1_d;
            dp_s2_q     <= dp_s2_d;
            dn_s2_q     <= dn_s2_d;
            line_prev_q <= line_prev_d;
            phase_q     <= phase_d;
            state_q     <= state_d;
            prev_j_q    <= prev_j_d;
            zeros_q     <= zeros_d;
            ones_q      <= ones_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_sop_q    <= rx_sop_d;
            rx_eop_q    <= rx_eop_d;
            rx_error_q  <= rx_error_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_sop    = rx_sop_q;
    assign rx_eop    = rx_eop_q;
    assign rx_error  = rx_error_q;
    assign rx_active = (state_q == ST_DATA);

endmodule

// File: tb/tb_usb_rx_phy.sv
// -----------------------------------------------------------------------------
// tb_usb_rx_phy
//
// Directed bench for usb_rx_phy. Packets are NRZI-encoded (with optional bit
// stuffing) by the bench and driven on the pins at negedge, 4 clocks per bit.
// A monitor samples DUT outputs 2 ns after each rising edge and logs bytes
// and strobes; each test task compares that log with hand-computed values.
// -----------------------------------------------------------------------------
module tb_usb_rx_phy;

    logic       clk;
    logic       reset;
    logic       data;
    logic       data_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sop;
    logic       rx_eop;
    logic       rx_error;
    logic       rx_active;
    logic       usb_reset;

    usb_rx_phy dut (
        .clock48  (clk),
        .reset    (reset),
        .data     (data),
        .data_n   (data_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_sop   (rx_sop),
        .rx_eop   (rx_eop),
        .rx_error (rx_error),
        .rx_active(rx_active),
        .usb_reset(usb_reset)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // ---------------- monitor / scoreboard log ----------------
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int  sop_cnt, eop_cnt, err_cnt, eop_err_cnt, clash_cnt, active_bad, ures_cnt;
    int  cyc, last_valid_cyc, eop_cyc, bytes_before_eop;
    bit  in_pkt;

    initial begin
        cyc = 0;
        in_pkt = 0;
    end

    always @(posedge clk) begin
        #2;
        cyc++;
        if (reset) begin
            in_pkt = 0;
        end else begin
            if (rx_valid) begin
                got_q.push_back(rx_data);
                last_valid_cyc = cyc;
            end
            if (rx_sop) begin
                sop_cnt++;
                in_pkt = 1;
            end
            if (rx_eop) begin
                eop_cnt++;
                eop_cyc = cyc;
                bytes_before_eop = got_q.size();
            end
            if (rx_error) err_cnt++;
            if (rx_eop && rx_error) eop_err_cnt++;
            if (rx_valid && rx_eop) clash_cnt++;
            if (usb_reset) ures_cnt++;
            if (rx_eop || rx_error) in_pkt = 0;
            if (rx_active !== in_pkt) active_bad++;
        end
    end

    // Called at negedge only, so it never races the monitor.
    task automatic clear_stats();
        got_q.delete();
        exp_q.delete();
        sop_cnt = 0; eop_cnt = 0; err_cnt = 0; eop_err_cnt = 0;
        clash_cnt = 0; active_bad = 0; ures_cnt = 0;
        last_valid_cyc = 0; eop_cyc = 0; bytes_before_eop = -1;
    endtask

    // ---------------- driver ----------------
    bit level_j = 1;
    int ones_run = 0;
    bit stuff_en = 1;

    task automatic drive_line(input logic dp, input logic dn, input int nclk);
        data   = dp;
        data_n = dn;
        repeat (nclk) @(negedge clk);
    endtask

    task automatic drive_level();
        if (level_j) drive_line(1'b1, 1'b0, 4);
        else         drive_line(1'b0, 1'b1, 4);
    endtask

    task automatic send_bit(input logic b);
        if (!b) level_j = !level_j;
        drive_level();
        ones_run = b ? ones_run + 1 : 0;
        if (stuff_en && ones_run == 6) begin
            level_j = !level_j;
            drive_level();
            ones_run = 0;
        end
    endtask

    task automatic send_sync();
        level_j = 1;
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_idle(input int nbits);
        level_j = 1;
        drive_line(1'b1, 1'b0, 4 * nbits);
    endtask

    task automatic send_eop();
        drive_line(1'b0, 1'b0, 8);
        send_idle(4);
    endtask

    task automatic check_bytes(input string name);
        n_chk++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL %s byte count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_chk++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL %s byte[%0d]: got %02h expected %02h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive_line(1'b1, 1'b0, 4);
        n_chk++;
        if ({rx_valid, rx_sop, rx_eop, rx_error, rx_active, usb_reset} !== 6'b0) begin
            n_err++;
            $display("FAIL reset strobes: got %06b expected 000000",
                     {rx_valid, rx_sop, rx_eop, rx_error, rx_active, usb_reset});
        end
        n_chk++;
        if (rx_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset rx_data: got %02h expected 00", rx_data);
        end
        reset = 1'b0;
        send_idle(4);
        clear_stats();
    endtask

    task automatic test_packet();
        clear_stats();
        stuff_en = 1;
        exp_q = '{8'h2D, 8'h00, 8'h10};
        send_sync();
        send_byte(8'h2D);
        send_byte(8'h00);
        send_byte(8'h10);
        send_eop();
        check_bytes("pkt");
        n_chk++;
        if (sop_cnt !== 1) begin n_err++; $display("FAIL pkt sop: got %0d expected 1", sop_cnt); end
        n_chk++;
        if (eop_cnt !== 1) begin n_err++; $display("FAIL pkt eop: got %0d expected 1", eop_cnt); end
        n_chk++;
        if (bytes_before_eop !== 3) begin
            n_err++; $display("FAIL pkt eop order: got %0d bytes before eop expected 3", bytes_before_eop);
        end
        n_chk++;
        if (eop_cyc - last_valid_cyc < 4) begin
            n_err++; $display("FAIL pkt valid-eop gap: got %0d expected >=4", eop_cyc - last_valid_cyc);
        end
        n_chk++;
        if (err_cnt !== 0) begin n_err++; $display("FAIL pkt error: got %0d expected 0", err_cnt); end
        n_chk++;
        if (active_bad !== 0 || clash_cnt !== 0) begin
            n_err++; $display("FAIL pkt active/clash: got %0d/%0d expected 0/0", active_bad, clash_cnt);
        end
    endtask

    task automatic test_stuffing();
        clear_stats();
        stuff_en = 1;
        exp_q = '{8'hFF, 8'hFF};
        send_sync();
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_eop();
        check_bytes("stuff");
        n_chk++;
        if (err_cnt !== 0 || eop_cnt !== 1) begin
            n_err++; $display("FAIL stuff err/eop: got %0d/%0d expected 0/1", err_cnt, eop_cnt);
        end
    endtask

    task automatic test_stuff_error();
        clear_stats();
        stuff_en = 0;
        send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        send_eop();
        n_chk++;
        if (err_cnt !== 1) begin n_err++; $display("FAIL stufferr error: got %0d expected 1", err_cnt); end
        n_chk++;
        if (got_q.size() !== 0) begin n_err++; $display("FAIL stufferr valid: got %0d expected 0", got_q.size()); end
        n_chk++;
        if (eop_cnt !== 0 || active_bad !== 0) begin
            n_err++; $display("FAIL stufferr eop/active: got %0d/%0d expected 0/0", eop_cnt, active_bad);
        end
        // Recovery with a clean packet
        clear_stats();
        stuff_en = 1;
        exp_q = '{8'h3C};
        send_sync();
        send_byte(8'h3C);
        send_eop();
        check_bytes("recover");
        n_chk++;
        if (err_cnt !== 0 || eop_cnt !== 1 || sop_cnt !== 1) begin
            n_err++; $display("FAIL recover err/eop/sop: got %0d/%0d/%0d expected 0/1/1", err_cnt, eop_cnt, sop_cnt);
        end
    endtask

    task automatic test_partial();
        clear_stats();
        stuff_en = 1;
        exp_q = '{8'hA5};
        send_sync();
        send_byte(8'hA5);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        send_eop();
        check_bytes("partial");
        n_chk++;
        if (eop_cnt !== 1 || err_cnt !== 1) begin
            n_err++; $display("FAIL partial eop/err: got %0d/%0d expected 1/1", eop_cnt, err_cnt);
        end
        n_chk++;
        if (eop_err_cnt !== 1) begin
            n_err++; $display("FAIL partial same-cycle eop+err: got %0d expected 1", eop_err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        stuff_en = 1;
        send_sync();
        send_byte(8'h2D);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({rx_valid, rx_sop, rx_eop, rx_error, rx_active, usb_reset} !== 6'b0 || rx_data !== 8'h00) begin
            n_err++;
            $display("FAIL midreset outputs: got %06b data %02h expected 000000 data 00",
                     {rx_valid, rx_sop, rx_eop, rx_error, rx_active, usb_reset}, rx_data);
        end
        reset = 1'b0;
        clear_stats();
        send_eop();
        n_chk++;
        if (sop_cnt + eop_cnt + err_cnt + got_q.size() !== 0) begin
            n_err++; $display("FAIL midreset strobes after: got sop %0d eop %0d err %0d valid %0d expected none",
                              sop_cnt, eop_cnt, err_cnt, got_q.size());
        end
        clear_stats();
        exp_q = '{8'h2D};
        send_sync();
        send_byte(8'h2D);
        send_eop();
        check_bytes("midreset next");
    endtask

    task automatic test_bus_reset();
        int n;
        clear_stats();
        send_idle(2);
`ifdef USB_RX_BUS_RESET_EN
        data = 1'b0; data_n = 1'b0;
        n = 0;
        while (usb_reset !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        // n counts clocks from the pin change; SE0 reaches the second flop after 2
        n_chk++;
        if (n - 2 < 117 || n - 2 > 123) begin
            n_err++; $display("FAIL busreset rise: got %0d cycles expected 117..123", n - 2);
        end
        repeat (200) @(negedge clk);
        n_chk++;
        if (usb_reset !== 1'b1) begin
            n_err++; $display("FAIL busreset hold: got %b expected 1", usb_reset);
        end
        data = 1'b1; data_n = 1'b0;
        n = 0;
        while (usb_reset !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (n > 5) begin
            n_err++; $display("FAIL busreset fall: got %0d cycles expected <=5", n);
        end
`else
        drive_line(1'b0, 1'b0, 400);
        n_chk++;
        if (ures_cnt !== 0) begin
            n_err++; $display("FAIL busreset tied: got %0d high cycles expected 0", ures_cnt);
        end
`endif
        send_idle(8);
        n_chk++;
        if (sop_cnt !== 0 || err_cnt !== 0) begin
            n_err++; $display("FAIL busreset sop/err: got %0d/%0d expected 0/0", sop_cnt, err_cnt);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset  = 1'b1;
        data   = 1'b1;
        data_n = 1'b0;
        clear_stats();
        repeat (2) @(negedge clk);
        test_reset();
        test_packet();
        test_stuffing();
        test_stuff_error();
        test_partial();
        test_reset_mid();
        test_bus_reset();
        test_packet();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
